// File: rtl/l1_pool_streamer_pkg.sv
// l1_pool_streamer_pkg
// Shared definitions for the layer-1 pooled-map streamer:
//   - layer-memory select encodings driven on csel
//   - layer-1 pooled map dimensions (32x32)
//   - controller state encodings
package l1_pool_streamer_pkg;

  localparam logic [2:0] CSEL_NONE = 3'b000;
  localparam logic [2:0] CSEL_L0   = 3'b001;
  localparam logic [2:0] CSEL_L1   = 3'b011;

  localparam int L1_ROWS  = 32;
  localparam int L1_COLS  = 32;
  localparam int L1_WORDS = L1_ROWS * L1_COLS;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/l1_stream_fifo.sv
// l1_stream_fifo
// Synchronous FIFO that absorbs words returning from the layer memory so the
// output handshake can stall without losing or duplicating data.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset (pointers and count only)
//   push       write push_data at the tail
//   push_data  word to store
//   pop        remove the head word (ignored when empty)
//   head       word at the head of the queue
//   count      number of stored words, 0..DEPTH
//   empty      count == 0
module l1_stream_fifo #(
  parameter int DATA_W = 20,
  parameter int DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic [DATA_W-1:0]            push_data,
  input  logic                         pop,
  output logic [DATA_W-1:0]            head,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic              do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign head   = mem[rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/l1_pool_streamer.sv
// l1_pool_streamer
// Reads the 32x32 max-pooled map out of layer-1 memory in raster order and
// streams it on a valid/ready port. A small FIFO hides the one-cycle memory
// read latency; reads are only issued when the FIFO plus the in-flight read
// leave room, so back-pressure never drops or repeats a word.
// Optional feature macro: L1_STREAM_CHECKSUM_EN (adds chk_sum output).
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      one-cycle pulse, begins a frame when idle
//   busy       frame in progress (cycle after start .. last handshake)
//   done       one-cycle pulse after the last handshake
//   crd        layer-memory read strobe
//   caddr_rd   layer-memory read address
//   csel       memory select, CSEL_L1 while reading
//   cdata_rd   read data, valid one cycle after crd
//   out_valid  out_data holds a word
//   out_ready  sink accepts the word
//   out_data   streamed word
//   out_last   word NUM_WORDS-1 is on out_data
//   out_index  raster index of the word on out_data
//   chk_sum    (L1_STREAM_CHECKSUM_EN only) running sum of accepted words
module l1_pool_streamer
  import l1_pool_streamer_pkg::*;
#(
  parameter int DATA_W     = 20,
  parameter int ADDR_W     = 12,
  parameter int NUM_WORDS  = L1_WORDS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     crd,
  output logic [ADDR_W-1:0]        caddr_rd,
  output logic [2:0]               csel,
  input  logic [DATA_W-1:0]        cdata_rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  output logic [ADDR_W-1:0]        out_index
`ifdef L1_STREAM_CHECKSUM_EN
  ,
  output logic [DATA_W+ADDR_W-1:0] chk_sum
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

  state_t            state;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] hs_cnt;
  logic              vld_p1;
  logic [CW-1:0]     fifo_count;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              accept;
  logic              room;
  logic              last_rd;
  logic              hs;
  logic              drained;

  assign accept  = (state == ST_IDLE) && start;
  // fifo_count + inflight must stay below the depth so every returning word has a slot
  assign room    = ({1'b0, fifo_count} + {{CW{1'b0}}, vld_p1}) < DEPTH_LIM;
  assign crd     = (state == ST_READ) && room;
  assign last_rd = crd && (rd_ptr == ADDR_W'(NUM_WORDS - 1));
  assign hs      = out_valid && out_ready;
  // FIFO becomes empty at this edge with nothing left to arrive
  assign drained = !vld_p1 && ((fifo_count == '0) || ((fifo_count == CW'(1)) && hs));

  assign busy      = (state == ST_READ) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);
  assign csel      = (state == ST_READ) ? CSEL_L1 : CSEL_NONE;
  assign caddr_rd  = rd_ptr;
  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? fifo_head : '0;
  assign out_index = hs_cnt;
  assign out_last  = (hs_cnt == ADDR_W'(NUM_WORDS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      rd_ptr <= '0;
      hs_cnt <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= crd;
      if (accept)   rd_ptr <= '0;
      else if (crd) rd_ptr <= rd_ptr + 1'b1;
      if (accept)   hs_cnt <= '0;
      else if (hs)  hs_cnt <= hs_cnt + 1'b1;
      case (state)
        ST_IDLE:  if (start)   state <= ST_READ;
        ST_READ:  if (last_rd) state <= ST_DRAIN;
        ST_DRAIN: if (drained) state <= ST_DONE;
        default:               state <= ST_IDLE;
      endcase
    end
  end

  // ---- stage p1: read in flight, cdata_rd valid, pushed into the FIFO ----
  l1_stream_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (vld_p1),
    .push_data (cdata_rd),
    .pop       (hs),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

`ifdef L1_STREAM_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      chk_sum <= '0;
    else if (accept) chk_sum <= '0;
    else if (hs)     chk_sum <= chk_sum + (DATA_W+ADDR_W)'(out_data);
  end
`else
  // no checksum accumulator in this build
`endif

endmodule

// File: doc/l1_pool_streamer.md
Name: l1_pool_streamer

Overview:
- Downstream consumer of the convolution/max-pool engine: once layer-1 memory (csel=3'b011) holds the 32x32 max-pooled map, reads it out in raster order and streams it on a valid/ready interface to the off-chip result port.
- Hides the 1-cycle memory read latency with a small FIFO so back-pressure never loses or duplicates a word.

Parameters:
- DATA_W, 20, result word width (same as cdata_rd).
- ADDR_W, 12, layer-memory address width.
- NUM_WORDS, 1024, words per frame (32x32 pooled map).
- FIFO_DEPTH, 4, output buffer depth (power of 2, >=2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a frame when idle.
- busy  output  1  high from the cycle after an accepted start until the last word handshakes.
- done  output  1  one-cycle pulse in the cycle after the last handshake.
- crd  output  1  layer-memory read strobe.
- caddr_rd  output  ADDR_W  read address.
- csel  output  3  memory select; 3'b011 while reading, 3'b000 otherwise.
- cdata_rd  input  DATA_W  read data, valid exactly one cycle after crd=1.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  sink accepts the word.
- out_data  output  DATA_W  streamed word.
- out_last  output  1  high with word NUM_WORDS-1.
- out_index  output  ADDR_W  raster index of the word on out_data.

Behaviour:
- Reset (reset=0, async): all outputs 0, FIFO empty, counters 0, state IDLE.
- States:
  - IDLE: start -> READ. start is ignored in every other state.
  - READ: issue reads; after the read of address NUM_WORDS-1 -> DRAIN.
  - DRAIN: wait until the FIFO is empty and no read is in flight -> DONE.
  - DONE: assert done for one cycle -> IDLE.
- Read issue:
  - crd=1 in a cycle only if (fifo_count + inflight) < FIFO_DEPTH, where inflight is 0 or 1.
  - caddr_rd = rd_ptr; rd_ptr increments on each issued read, from 0 to NUM_WORDS-1.
  - Captured cdata_rd is pushed into the FIFO the following cycle.
  - Throughput is 1 word/cycle with out_ready held high after a 2-cycle first-word latency: start at cycle t, first crd at t+1, out_valid at t+3.
- Output handshake:
  - out_valid = FIFO non-empty. A word transfers when out_valid && out_ready.
  - out_data, out_index and out_last hold stable while out_valid=1 and out_ready=0.
  - out_index comes from a handshake counter; out_last is high when out_index==NUM_WORDS-1.
- Simultaneous push and pop on a full FIFO is legal; count is unchanged. A push into a full FIFO cannot occur by construction; the bench asserts this.
- Boundaries:
  - busy falls in the same cycle done pulses.
  - A start that coincides with done is ignored.
  - Reset mid-frame aborts immediately; the next start restarts from address 0.
- Data is passed through unmodified (no sign or width change).

Optional Feature:
- Macro L1_STREAM_CHECKSUM_EN.
- Defined: extra output port chk_sum [DATA_W+ADDR_W-1:0], unsigned running sum of all handshaked words. It clears on accepted start and is stable and valid when done pulses.
- Undefined: the port and the adder are absent; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - the CSEL encodings (CSEL_NONE=3'b000, CSEL_L0=3'b001, CSEL_L1=3'b011);
  - L1 map dimensions (L1_ROWS=32, L1_COLS=32);
  - the state enum (ST_IDLE, ST_READ, ST_DRAIN, ST_DONE).
- One natural sub-module: l1_stream_fifo, a synchronous FIFO with count output, sized by FIFO_DEPTH.

Test Plan:
- Memory preloaded with word[i]=i, out_ready held 1, start pulse -> 1024 words with out_data=0..1023 on consecutive cycles; out_last only at index 1023; done exactly one cycle after; busy high for 1026 cycles.
- out_ready toggled 1-0-1-0 -> every word appears exactly once in order; crd never issued while fifo_count+inflight==4; no overflow assertion fires.
- out_ready held 0 for 20 cycles after start -> exactly 4 reads issued, out_data=0 held stable; releasing out_ready resumes streaming with no gap or duplicate.
- reset driven low at word 500 and then a new start -> outputs 0 during reset; the new frame begins at caddr_rd=0 with out_index=0.
- start pulsed while busy and again on the done cycle -> both ignored; only one frame is streamed.
- With L1_STREAM_CHECKSUM_EN and word[i]=20'hFFFFF for all i -> chk_sum=1024*20'hFFFFF=32'h3FFFFC00 at done.
